change_payout_ctrl: RTL and testbench

Sequences refund payout for the vending machine. It accepts a change amount from the vend FSM and drives a coin hopper through a request/acknowledge handshake, one coin at a time. Coin choice is greedy (5 zł, then 2 zł, then 1 zł) and skips denominations the hopper reports empty. It reports completion, coins paid so far, and any unpayable remainder back to the vend FSM and the change display.

---
 rtl/vend_pkg.sv | 38 +++
 rtl/payout_coin_pick.sv | 24 ++
 rtl/change_payout_ctrl.sv | 159 +++++++++++++++
 tb/tb_change_payout_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared vending definitions: coin encodings and values, stock bit indices,
// payout FSM states and a coin-value helper.
package vend_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_1    = 2'b01,
    COIN_2    = 2'b10,
    COIN_5    = 2'b11
  } coin_sel_e;

  localparam int unsigned COIN_VAL_1 = 1;
  localparam int unsigned COIN_VAL_2 = 2;
  localparam int unsigned COIN_VAL_5 = 5;

  localparam int unsigned STOCK_IDX_1 = 0;
  localparam int unsigned STOCK_IDX_2 = 1;
  localparam int unsigned STOCK_IDX_5 = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_REQ,
    ST_GAP,
    ST_DONE,
    ST_ERROR
  } payout_state_e;

  function automatic int unsigned coin_value(logic [1:0] sel);
    case (sel)
      COIN_1:  coin_value = COIN_VAL_1;
      COIN_2:  coin_value = COIN_VAL_2;
      COIN_5:  coin_value = COIN_VAL_5;
      default: coin_value = 0;
    endcase
  endfunction

endpackage

// File: rtl/payout_coin_pick.sv
// Greedy coin choice: largest stocked denomination not exceeding the amount
// still owed, or COIN_NONE when nothing qualifies.
module payout_coin_pick
  import vend_pkg::*;
#(
  parameter int unsigned AMT_W = 8
) (
  input  logic [AMT_W-1:0] remaining,
  input  logic [2:0]       stock_empty,
  output logic [1:0]       coin_sel_c
);

  always_comb begin
    coin_sel_c = COIN_NONE;
    if (remaining >= AMT_W'(COIN_VAL_5) && !stock_empty[STOCK_IDX_5]) begin
      coin_sel_c = COIN_5;
    end else if (remaining >= AMT_W'(COIN_VAL_2) && !stock_empty[STOCK_IDX_2]) begin
      coin_sel_c = COIN_2;
    end else if (remaining >= AMT_W'(COIN_VAL_1) && !stock_empty[STOCK_IDX_1]) begin
      coin_sel_c = COIN_1;
    end
  end

endmodule

// File: rtl/change_payout_ctrl.sv
// Change payout sequencer: pays an amount one coin at a time over a hopper
// req/ack handshake. Optional hopper ack timeout under `PAYOUT_TIMEOUT_EN.
module change_payout_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned AMT_W          = 8,
  parameter int unsigned HOPPER_TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic [2:0]       stock_empty,
  output logic             coin_req,
  output logic [1:0]       coin_sel,
  input  logic             coin_ack,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [AMT_W-1:0] paid,
  output logic [AMT_W-1:0] remaining
);

  payout_state_e    state_q, state_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic [AMT_W-1:0] paid_q, paid_d;
  logic [1:0]       coin_sel_q, coin_sel_d;
  logic             coin_req_q, coin_req_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [1:0]       pick_sel;
  logic [AMT_W-1:0] coin_val;

`ifdef PAYOUT_TIMEOUT_EN
  localparam int unsigned CNT_W = (HOPPER_TIMEOUT > 1) ? $clog2(HOPPER_TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (HOPPER_TIMEOUT == 32'd0);
`endif

  payout_coin_pick #(.AMT_W(AMT_W)) u_pick (
    .remaining  (remaining_q),
    .stock_empty(stock_empty),
    .coin_sel_c (pick_sel)
  );

  assign coin_val = AMT_W'(coin_value(coin_sel_q));

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    paid_d      = paid_q;
    coin_sel_d  = coin_sel_q;
    coin_req_d  = coin_req_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;
`ifdef PAYOUT_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (start) begin
          remaining_d = amount;
          paid_d      = '0;
          error_d     = 1'b0;
          busy_d      = 1'b1;
          state_d     = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (remaining_q == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end else if (pick_sel == COIN_NONE) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_ERROR;
        end else begin
          coin_sel_d = pick_sel;
          coin_req_d = 1'b1;
          state_d    = ST_REQ;
`ifdef PAYOUT_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      ST_REQ: begin
        if (coin_ack) begin
          remaining_d = remaining_q - coin_val;
          paid_d      = paid_q + coin_val;
          coin_req_d  = 1'b0;
          coin_sel_d  = COIN_NONE;
          state_d     = ST_GAP;
        end
`ifdef PAYOUT_TIMEOUT_EN
        // Last allowed request cycle without ack: give up on this coin.
        else if (cnt_q == CNT_W'(HOPPER_TIMEOUT - 1)) begin
          coin_req_d = 1'b0;
          coin_sel_d = COIN_NONE;
          error_d    = 1'b1;
          busy_d     = 1'b0;
          state_d    = ST_ERROR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_GAP:  state_d = ST_SELECT;
      ST_DONE: state_d = ST_IDLE;
      default: begin
        coin_req_d = 1'b0;
        coin_sel_d = COIN_NONE;
        busy_d     = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      paid_q      <= '0;
      coin_sel_q  <= COIN_NONE;
      coin_req_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef PAYOUT_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      paid_q      <= paid_d;
      coin_sel_q  <= coin_sel_d;
      coin_req_q  <= coin_req_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef PAYOUT_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign coin_req  = coin_req_q;
  assign coin_sel  = coin_sel_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign paid      = paid_q;
  assign remaining = remaining_q;

endmodule

// File: tb/tb_change_payout_ctrl.sv
// Directed bench for change_payout_ctrl with a hopper model and a coin
// scoreboard; the timeout scenario runs only with PAYOUT_TIMEOUT_EN.
module tb_change_payout_ctrl;

  localparam int unsigned AMT_W = 8;
  localparam int unsigned BUDGET = 400;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [AMT_W-1:0] amount = '0;
  logic [2:0]       stock_empty = 3'b000;
  logic             coin_req;
  logic [1:0]       coin_sel;
  logic             coin_ack = 1'b0;
  logic             busy, done, error;
  logic [AMT_W-1:0] paid, remaining;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [1:0] exp_q[$];
  int         ack_delay = 0;
  bit         ack_en = 1'b1;
  int         wait_cnt = 0;
  bit         req_seen = 1'b0;
  logic [1:0] cur_sel = 2'b00;
  int         req_cycles = 0;

  change_payout_ctrl #(
    .AMT_W(AMT_W)
`ifdef PAYOUT_TIMEOUT_EN
    , .HOPPER_TIMEOUT(16)
`endif
  ) dut (
    .clk(clk), .reset(reset), .start(start), .amount(amount),
    .stock_empty(stock_empty), .coin_req(coin_req), .coin_sel(coin_sel),
    .coin_ack(coin_ack), .busy(busy), .done(done), .error(error),
    .paid(paid), .remaining(remaining)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hopper model: checks each new request against the scoreboard, then acks after ack_delay cycles.
  always @(negedge clk) begin
    if (coin_ack) begin
      coin_ack = 1'b0;
    end else if (coin_req) begin
      if (!req_seen) begin
        req_seen = 1'b1;
        wait_cnt = 0;
        if (exp_q.size() == 0) begin
          chk("unexpected_coin_req", 32'(coin_sel), 32'hFFFF);
          cur_sel = coin_sel;
        end else begin
          cur_sel = exp_q.pop_front();
          chk("coin_sel_order", 32'(coin_sel), 32'(cur_sel));
        end
      end else begin
        chk("coin_sel_stable", 32'(coin_sel), 32'(cur_sel));
      end
      req_cycles++;
      if (ack_en && wait_cnt >= ack_delay) coin_ack = 1'b1;
      else wait_cnt++;
    end else begin
      req_seen = 1'b0;
    end
  end

  // Greedy reference: queue expected coins, return the unpayable remainder.
  task automatic start_pay(input int amt, output int rem);
    rem = amt;
    forever begin
      if (rem >= 5 && !stock_empty[2]) begin exp_q.push_back(2'b11); rem -= 5; end
      else if (rem >= 2 && !stock_empty[1]) begin exp_q.push_back(2'b10); rem -= 2; end
      else if (rem >= 1 && !stock_empty[0]) begin exp_q.push_back(2'b01); rem -= 1; end
      else break;
    end
    @(negedge clk);
    start = 1'b1;
    amount = AMT_W'(amt);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && error !== 1'b1 && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= BUDGET) chk("wait_end_budget", 32'(cyc), 32'(BUDGET - 1));
  endtask

  initial begin
    int rem, cyc, n, base;

    #1;
    chk("rst_coin_req", 32'(coin_req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_paid", 32'(paid), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // amount=8, all stocked, immediate ack
    ack_delay = 0;
    stock_empty = 3'b000;
    start_pay(8, rem);
    wait_end(cyc);
    chk("a8_done_cycle", 32'(cyc), 11);
    chk("a8_done", 32'(done), 1);
    chk("a8_paid", 32'(paid), 8);
    chk("a8_remaining", 32'(remaining), 0);
    chk("a8_busy_at_done", 32'(busy), 0);
    chk("a8_coins_left", 32'(exp_q.size()), 0);
    @(negedge clk);
    chk("a8_done_pulse", 32'(done), 0);

    // amount=0: no coin request
    base = req_cycles;
    start_pay(0, rem);
    chk("a0_busy", 32'(busy), 1);
    wait_end(cyc);
    chk("a0_done_cycle", 32'(cyc), 2);
    chk("a0_paid", 32'(paid), 0);
    chk("a0_no_req", 32'(req_cycles - base), 0);

    // amount=4, 2 zl tube empty: four 1 zl coins
    stock_empty = 3'b010;
    start_pay(4, rem);
    n = 4 - rem;
    wait_end(cyc);
    chk("a4_done", 32'(done), 1);
    chk("a4_done_cycle", 32'(cyc), 32'(2 + 3 * 4));
    chk("a4_paid", 32'(paid), 32'(n));
    chk("a4_coins_left", 32'(exp_q.size()), 0);

    // amount=3, 1 and 2 zl empty: immediate error
    stock_empty = 3'b011;
    base = req_cycles;
    start_pay(3, rem);
    wait_end(cyc);
    chk("a3_error", 32'(error), 1);
    chk("a3_err_cycle", 32'(cyc), 2);
    chk("a3_remaining", 32'(remaining), 32'(rem));
    chk("a3_paid", 32'(paid), 0);
    chk("a3_busy", 32'(busy), 0);
    chk("a3_no_req", 32'(req_cycles - base), 0);
    repeat (3) @(negedge clk);
    chk("a3_error_sticky", 32'(error), 1);
    stock_empty = 3'b000;

`ifdef PAYOUT_TIMEOUT_EN
    // amount=5 with a silent hopper: 16 request cycles then error
    ack_en = 1'b0;
    base = req_cycles;
    start_pay(5, rem);
    wait_end(cyc);
    chk("to_error", 32'(error), 1);
    chk("to_req_cycles", 32'(req_cycles - base), 16);
    chk("to_err_cycle", 32'(cyc), 18);
    chk("to_remaining", 32'(remaining), 5);
    chk("to_coin_req_low", 32'(coin_req), 0);
    ack_en = 1'b1;
    start_pay(5, rem);
    chk("to_restart_clears_error", 32'(error), 0);
    wait_end(cyc);
    chk("to_restart_paid", 32'(paid), 5);
    chk("to_restart_done", 32'(done), 1);
`endif

    // amount=7, ack after 4 cycles; ignored restart, then reset mid-payout
    ack_delay = 4;
    start_pay(7, rem);
    @(negedge clk);
    chk("a7_first_req", 32'(coin_req), 1);
    start = 1'b1;
    amount = AMT_W'(3);
    @(negedge clk);
    start = 1'b0;
    chk("a7_ignored_remaining", 32'(remaining), 7);
    chk("a7_ignored_req", 32'(coin_req), 1);
    chk("a7_ignored_busy", 32'(busy), 1);
    cyc = 0;
    while (!(paid == AMT_W'(5) && coin_req === 1'b1) && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    chk("a7_second_req_seen", 32'(cyc < BUDGET), 1);
    chk("a7_second_sel", 32'(coin_sel), 32'h2);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_coin_req", 32'(coin_req), 0);
    chk("rst_mid_coin_sel", 32'(coin_sel), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_done", 32'(done), 0);
    chk("rst_mid_paid", 32'(paid), 0);
    chk("rst_mid_remaining", 32'(remaining), 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1 || coin_req === 1'b1) n++;
    end
    chk("rst_mid_quiet_after", 32'(n), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
